// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The pipeline side is the master; the unit itself is the slave.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Signed operands run as magnitudes; the sign correction happens in the FIX cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               is_div_q, is_div_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               dbz_q, dbz_d;

    logic               is_signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               in_fix;

    assign is_signed_op = ~bus.op[0];
    assign a_mag = (is_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (is_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign in_fix = (state_q == ST_FIX);

    // acc_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mc_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - mc_q;
        if (div_shift >= {1'b0, mc_q}) begin
            div_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        prod_fix = neg_quo_q ? -acc_q : acc_q;
        quo_fix  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mc_d      = mc_q;
        acc_d     = acc_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = bus.op[1];
                            neg_quo_d = is_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d = is_signed_op && bus.a[WIDTH-1];
                            mc_d      = b_mag;
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            cnt_d     = '0;
                            dbz_d     = 1'b0;
                            if (bus.op[1] && (bus.b == '0)) begin
                                // Architectural divide-by-zero result is staged directly for FIX.
                                dz_d    = 1'b1;
                                acc_d   = {bus.a, {WIDTH{1'b1}}};
                                state_d = ST_FIX;
                            end else begin
                                dz_d    = 1'b0;
                                state_d = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                if (bus.cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.cancel) begin
                    if (dz_q) begin
                        hi_d  = acc_q[2*WIDTH-1:WIDTH];
                        lo_d  = acc_q[WIDTH-1:0];
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the unit holds only flops, no memories, so the whole state can be cleared here.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mc_q      <= '0;
            acc_q     <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mc_q      <= mc_d;
            acc_q     <= acc_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            dbz_q     <= dbz_d;
        end
    end

    // done and the live div_by_zero view are suppressed by a flush arriving in FIX.
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = in_fix && !bus.cancel;
    assign bus.div_by_zero = dbz_q || (in_fix && dz_q && !bus.cancel);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        logic            dz;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        dz  = 1'b0;
        res = '0;
        case (op)
            3'b000: res = sa * sb;
            3'b001: res = ua * ub;
            3'b010, 3'b011: begin
                if (b == '0) begin
                    dz  = 1'b1;
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 3'b010) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    uq  = ua / ub;
                    ur  = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = '0;
        endcase
        return {dz, res};
    endfunction

    task automatic wait_done(inout int k, output logic seen, output int busy_n);
        seen   = 1'b0;
        busy_n = 0;
        while (k <= 60) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = 1'b1;
                return;
            end
            tick();
            k++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [64:0] exp;
        int          k;
        int          busy_n;
        logic        seen;
        exp = model(op, a, b);
        issue(op, a, b);
        k = 1;
        wait_done(k, seen, busy_n);
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, k, exp[64] ? 1 : W + 1);
        check({tag, " busy_cycles"}, busy_n, exp[64] ? 1 : W + 1);
        check({tag, " dbz_at_done"}, bus.div_by_zero, exp[64]);
        tick();
        check({tag, " busy_after"}, bus.busy, 0);
        check({tag, " done_after"}, bus.done, 0);
        check({tag, " hi"}, bus.hi, exp[63:32]);
        check({tag, " lo"}, bus.lo, exp[31:0]);
        check({tag, " dbz_after"}, bus.div_by_zero, exp[64]);
    endtask

    initial begin : stim
        int          k;
        int          busy_n;
        int          done_n;
        logic        seen;
        logic [2:0]  rop;
        logic [W-1:0] ra, rb;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset dbz", bus.div_by_zero, 0);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        reset = 1'b0;
        tick();

        run_md("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max hi const", bus.hi, 32'hFFFF_FFFE);
        check("multu_max lo const", bus.lo, 32'h0000_0001);
        run_md("mult_neg7x3", 3'b000, 32'hFFFF_FFF9, 32'd3);
        check("mult_neg7x3 lo const", bus.lo, 32'hFFFF_FFEB);
        run_md("mult_min_sq", 3'b000, 32'h8000_0000, 32'h8000_0000);
        check("mult_min_sq hi const", bus.hi, 32'h4000_0000);
        run_md("div_neg7by2", 3'b010, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7by2 lo const", bus.lo, 32'hFFFF_FFFD);
        run_md("divu_100by7", 3'b011, 32'd100, 32'd7);
        check("divu_100by7 lo const", bus.lo, 32'd14);
        run_md("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_overflow lo const", bus.lo, 32'h8000_0000);
        run_md("divu_by_zero", 3'b011, 32'd5, 32'd0);
        check("divu_by_zero hi const", bus.hi, 32'd5);

        // MTHI then MTLO back to back; the sticky flag must survive them.
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'h1234;
        tick();
        check("mthi hi", bus.hi, 32'h1234);
        check("mthi busy", bus.busy, 0);
        check("mthi done", bus.done, 0);
        bus.op = 3'b101;
        bus.a  = 32'h5678;
        tick();
        bus.start = 1'b0;
        check("mtlo lo", bus.lo, 32'h5678);
        check("mtlo hi kept", bus.hi, 32'h1234);
        check("mtlo busy", bus.busy, 0);
        check("mtlo done", bus.done, 0);
        check("mtx dbz sticky", bus.div_by_zero, 1);

        // Reserved op is a no-op.
        issue(3'b110, 32'hAAAA_AAAA, 32'd1);
        check("reserved busy", bus.busy, 0);
        check("reserved hi", bus.hi, 32'h1234);
        check("reserved lo", bus.lo, 32'h5678);

        // A second start while busy must be ignored.
        issue(3'b001, 32'd3, 32'd5);
        k = 1;
        repeat (3) begin
            tick();
            k++;
        end
        issue(3'b011, 32'd100, 32'd7);
        k++;
        wait_done(k, seen, busy_n);
        check("ignore done_seen", seen, 1);
        check("ignore latency", k, W + 1);
        check("ignore dbz cleared", bus.div_by_zero, 0);
        tick();
        check("ignore hi", bus.hi, 32'd0);
        check("ignore lo", bus.lo, 32'd15);
        check("ignore busy_after", bus.busy, 0);

        // Flush in RUN at cycle N+10.
        issue(3'b000, 32'h0123_4567, 32'h0008_9ABC);
        repeat (9) tick();
        bus.cancel = 1'b1;
        #1;
        check("cancel_run done", bus.done, 0);
        tick();
        bus.cancel = 1'b0;
        check("cancel_run busy", bus.busy, 0);
        done_n = 0;
        busy_n = 0;
        repeat (40) begin
            if (bus.done) done_n++;
            if (bus.busy) busy_n++;
            tick();
        end
        check("cancel_run no_done", done_n, 0);
        check("cancel_run stays_idle", busy_n, 0);
        check("cancel_run hi", bus.hi, 32'd0);
        check("cancel_run lo", bus.lo, 32'd15);

        // Flush in FIX: a divide-by-zero sits in FIX right after issue.
        issue(3'b011, 32'd9, 32'd0);
        bus.cancel = 1'b1;
        #1;
        check("cancel_fix done", bus.done, 0);
        check("cancel_fix dbz", bus.div_by_zero, 0);
        tick();
        bus.cancel = 1'b0;
        check("cancel_fix busy", bus.busy, 0);
        check("cancel_fix hi", bus.hi, 32'd0);
        check("cancel_fix lo", bus.lo, 32'd15);

        // cancel beats start in IDLE, for MTHI and for a multiply.
        bus.cancel = 1'b1;
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        check("cancel_idle mthi hi", bus.hi, 32'd0);
        issue(3'b000, 32'd6, 32'd7);
        bus.cancel = 1'b0;
        check("cancel_idle mult busy", bus.busy, 0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = 32'($urandom_range(1, 300));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_md($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        // Asynchronous reset in the middle of RUN clears HI/LO at once.
        run_md("pre_reset", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b000, 32'h0000_0123, 32'h0000_0456);
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset hi", bus.hi, 0);
        check("async_reset lo", bus.lo, 0);
        check("async_reset busy", bus.busy, 0);
        check("async_reset done", bus.done, 0);
        #1;
        reset = 1'b0;
        tick();
        check("post_reset busy", bus.busy, 0);
        run_md("post_reset div", 3'b010, 32'd7, 32'hFFFF_FFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the MIPS datapath.
- Sits beside the ALU in the execute stage.
- The pipeline stalls on busy, then reads HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits. Legal values are even and at least 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue request, sampled on a rising clk edge.
- op  input  3  operation select:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 11x reserved (no operation)
- a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  input  WIDTH  rt operand: multiplier or divisor.
- cancel  input  1  pipeline flush. Aborts the operation in flight.
- busy  output  1  high while a mul/div is in flight.
- done  output  1  one-cycle pulse when HI/LO have just been updated by a mul/div.
- div_by_zero  output  1  sticky flag. Valid alongside done for DIV and DIVU.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous) forces:
  - hi = 0, lo = 0
  - busy = 0, done = 0, div_by_zero = 0
  - state = IDLE, counter = 0
  - Reset during RUN or FIX discards the operation. No partial result reaches HI/LO.
- States: IDLE → RUN → FIX → IDLE.
- IDLE:
  - start with op = MULT/MULTU/DIV/DIVU: latch the operands, go to RUN, busy = 1 from the next cycle.
  - For signed ops, latch |a| and |b| and record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1].
  - start with op = MTHI or MTLO: write a into hi or lo at that edge. busy and done stay 0, state stays IDLE.
  - start with a reserved op: ignored.
- start while busy = 1 is ignored. The issuing stage must hold the instruction.
- RUN, multiply: radix-2 shift-add over the 2*WIDTH-bit product. One multiplier bit per cycle, WIDTH cycles.
- RUN, divide: restoring divide. One quotient bit per cycle, WIDTH cycles.
- Divide by zero (b == 0 at issue):
  - Skip RUN and go directly to FIX.
  - Result: lo = all ones, hi = a as issued (original signed value).
  - div_by_zero = 1.
- FIX, one cycle:
  - Multiply: negate the product if signed and sign_q = 1.
  - Divide: negate the quotient if signed and sign_q = 1; negate the remainder if signed and sign_r = 1.
  - Write the result atomically: hi = product[2W-1:W] or remainder; lo = product[W-1:0] or quotient.
  - Pulse done, drop busy, return to IDLE.
- Latency:
  - Normal mul/div: start sampled at edge N, done high in cycle N+WIDTH+1, busy high in cycles N+1 .. N+WIDTH+1.
  - Divide by zero: done high in cycle N+1.
- Overflow case: DIV with a = 0x8000_0000 and b = -1 gives lo = 0x8000_0000, hi = 0, by natural wrap. No flag.
- Signed rules: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- MULT of (-2^(W-1)) × (-2^(W-1)) gives hi:lo = 2^(2W-2).
- cancel:
  - In RUN or FIX: return to IDLE next edge. HI/LO unchanged, no done pulse, busy drops.
  - cancel together with start in IDLE: cancel wins, nothing issued. This includes MTHI/MTLO.
- div_by_zero: set on divide-by-zero completion; cleared when the next mul/div is issued.
- hi and lo change only on MTHI/MTLO or on the FIX write.

Test Plan:
- MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → done at cycle N+33, hi = 0xFFFF_FFFE, lo = 0x0000_0001, busy high for exactly 33 cycles.
- MULT a = -7 (0xFFFF_FFF9), b = 3 → hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB. Then MULT of 0x8000_0000 by itself → hi = 0x4000_0000, lo = 0.
- DIV a = -7, b = 2 → lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1). DIVU a = 100, b = 7 → lo = 14, hi = 2.
- DIV a = 0x8000_0000, b = 0xFFFF_FFFF → lo = 0x8000_0000, hi = 0, div_by_zero = 0. DIVU a = 5, b = 0 → done at N+1, lo = 0xFFFF_FFFF, hi = 5, div_by_zero = 1.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi = 0x1234, lo = 0x5678 after one edge each, busy and done never assert. Then a second start during busy is ignored: the result matches the first op only.
- Start a MULT, assert cancel at cycle N+10 → busy drops next edge, no done, HI/LO keep their prior values. Repeat with reset at N+10 → hi = lo = 0 immediately, asynchronously.
